// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared widths, constants and FSM states for the ann block
package ann_pkg;
    localparam int INPUT_SIZE = 13;
    localparam int INPUT_NUM  = 4;
    localparam int NEURON_NUM = 8;
    localparam int W          = INPUT_SIZE * 12;
    localparam int NW         = INPUT_NUM * NEURON_NUM + NEURON_NUM;
    localparam int OUT_BASE   = INPUT_NUM * NEURON_NUM;
    localparam int LMS_SHIFT  = 20;
    localparam logic signed [W-1:0] SCALE = W'(1000);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_HIDDEN,
        S_OUTPUT,
        S_UPDATE
    } state_t;
endpackage

// File: rtl/ann_neuron.sv
// rtl/ann_neuron.sv - 4-input MAC with ReLU and /1000 rescale
module ann_neuron
    import ann_pkg::*;
(
    input  logic signed [W-1:0] x0,
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] x2,
    input  logic signed [W-1:0] x3,
    input  logic signed [W-1:0] w0,
    input  logic signed [W-1:0] w1,
    input  logic signed [W-1:0] w2,
    input  logic signed [W-1:0] w3,
    output logic signed [W-1:0] h
);
    logic signed [W-1:0] s;

    always_comb begin
        s = w0 * x0 + w1 * x1 + w2 * x2 + w3 * x3;
        // strictly positive sums pass; zero and negative clamp
        if (!s[W-1] && (s != '0)) h = s / SCALE;
        else                      h = '0;
    end
endmodule

// File: rtl/ann.sv
// rtl/ann.sv - 4-8-1 ReLU network with serial weight access and LMS output training
module ann
    import ann_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset_l,
    input  logic signed [W-1:0] Temperature_in_0,
    input  logic signed [W-1:0] Temperature_in_1,
    input  logic signed [W-1:0] Temperature_in_2,
    input  logic signed [W-1:0] Temperature_in_3,
    input  logic signed [W-1:0] Weight_in,
    input  logic signed [W-1:0] Target,
    input  logic                training_enable_h,
    input  logic                tb_rev_ready_h,
    input  logic                Weight_Save_enable,
    input  logic                Weight_Load_enable,
    output logic signed [W-1:0] Data_out,
    output logic signed [W-1:0] New_weight_out,
    output logic                Ready_Signal
);
    state_t              state_q, state_d;
    logic                ready_prev;
    logic                start;
    logic [5:0]          ptr, ptr_next;
    logic signed [W-1:0] w   [NW];
    logic signed [W-1:0] x_q [INPUT_NUM];
    logic signed [W-1:0] h_c [NEURON_NUM];
    logic signed [W-1:0] h_q [NEURON_NUM];
    logic signed [W-1:0] y;
    logic signed [W-1:0] err;

    assign start    = tb_rev_ready_h && !ready_prev;
    assign ptr_next = (ptr == 6'(NW - 1)) ? 6'd0 : ptr + 6'd1;

    for (genvar j = 0; j < NEURON_NUM; j++) begin : g_neuron
        ann_neuron u_neuron (
            .x0 (x_q[0]),
            .x1 (x_q[1]),
            .x2 (x_q[2]),
            .x3 (x_q[3]),
            .w0 (w[4*j+0]),
            .w1 (w[4*j+1]),
            .w2 (w[4*j+2]),
            .w3 (w[4*j+3]),
            .h  (h_c[j])
        );
    end

    always_comb begin
        y = '0;
        for (int j = 0; j < NEURON_NUM; j++) y = y + w[OUT_BASE+j] * h_q[j];
        // Data_out still holds this inference's y while in UPDATE
        err = Target * SCALE - Data_out;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LATCH;
            S_LATCH:  state_d = S_HIDDEN;
            S_HIDDEN: state_d = S_OUTPUT;
            S_OUTPUT: state_d = training_enable_h ? S_UPDATE : S_IDLE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset_l) begin
        if (Reset_l) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge Clk or posedge Reset_l) begin
        if (Reset_l) begin
            ready_prev     <= 1'b0;
            ptr            <= '0;
            Data_out       <= '0;
            New_weight_out <= '0;
            Ready_Signal   <= 1'b0;
            for (int k = 0; k < NW; k++)         w[k]   <= '0;
            for (int i = 0; i < INPUT_NUM; i++)  x_q[i] <= '0;
            for (int j = 0; j < NEURON_NUM; j++) h_q[j] <= '0;
        end else begin
            ready_prev   <= tb_rev_ready_h;
            Ready_Signal <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Weight_Save_enable) begin
                        w[ptr] <= Weight_in;
                        ptr    <= ptr_next;
                    end else if (Weight_Load_enable) begin
                        New_weight_out <= w[ptr];
                        ptr            <= ptr_next;
                    end else begin
                        ptr <= '0;
                    end
                end
                S_LATCH: begin
                    x_q[0] <= Temperature_in_0;
                    x_q[1] <= Temperature_in_1;
                    x_q[2] <= Temperature_in_2;
                    x_q[3] <= Temperature_in_3;
                end
                S_HIDDEN: begin
                    for (int j = 0; j < NEURON_NUM; j++) h_q[j] <= h_c[j];
                end
                S_OUTPUT: begin
                    Data_out     <= y;
                    Ready_Signal <= 1'b1;
                end
                S_UPDATE: begin
                    for (int j = 0; j < NEURON_NUM; j++)
                        w[OUT_BASE+j] <= w[OUT_BASE+j] + ((err * h_q[j]) >>> LMS_SHIFT);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ann.sv
// tb/tb_ann.sv - self-checking bench for ann against a behavioural network model
module tb_ann;
    import ann_pkg::*;

    localparam int WB = 156;

    logic                 Clk = 1'b0;
    logic                 Reset_l;
    logic signed [WB-1:0] t0, t1, t2, t3, Weight_in, Target;
    logic                 training_enable_h, tb_rev_ready_h;
    logic                 Weight_Save_enable, Weight_Load_enable;
    logic signed [WB-1:0] Data_out, New_weight_out;
    logic                 Ready_Signal;

    int checks   = 0;
    int failures = 0;

    longint               m_w [40];
    longint               m_x [4];
    longint               m_h [8];
    logic signed [WB-1:0] rb  [40];
    logic signed [WB-1:0] exp_v;
    logic signed [WB-1:0] got;
    int                   pulses, ready_cyc;

    always #5 Clk = ~Clk;

    ann dut (
        .Clk                (Clk),
        .Reset_l            (Reset_l),
        .Temperature_in_0   (t0),
        .Temperature_in_1   (t1),
        .Temperature_in_2   (t2),
        .Temperature_in_3   (t3),
        .Weight_in          (Weight_in),
        .Target             (Target),
        .training_enable_h  (training_enable_h),
        .tb_rev_ready_h     (tb_rev_ready_h),
        .Weight_Save_enable (Weight_Save_enable),
        .Weight_Load_enable (Weight_Load_enable),
        .Data_out           (Data_out),
        .New_weight_out     (New_weight_out),
        .Ready_Signal       (Ready_Signal)
    );

    function automatic longint model_forward();
        longint s, y;
        y = 0;
        for (int j = 0; j < 8; j++) begin
            s = 0;
            for (int i = 0; i < 4; i++) s += m_w[4*j+i] * m_x[i];
            m_h[j] = (s > 0) ? s / 1000 : 0;
            y += m_w[32+j] * m_h[j];
        end
        return y;
    endfunction

    task automatic model_train(input longint target, input longint y);
        longint e;
        e = target * 1000 - y;
        for (int j = 0; j < 8; j++) m_w[32+j] += (e * m_h[j]) >>> 20;
    endtask

    task automatic apply_reset();
        Reset_l = 1'b1;
        t0 = '0; t1 = '0; t2 = '0; t3 = '0;
        Weight_in = '0; Target = '0;
        training_enable_h = 1'b0; tb_rev_ready_h = 1'b0;
        Weight_Save_enable = 1'b0; Weight_Load_enable = 1'b0;
        for (int k = 0; k < 40; k++) m_w[k] = 0;
        repeat (2) @(negedge Clk);
        Reset_l = 1'b0;
        @(negedge Clk);
    endtask

    task automatic write_all();
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            Weight_Save_enable = 1'b1;
            Weight_in = WB'(m_w[k]);
        end
        @(negedge Clk);
        Weight_Save_enable = 1'b0;
        @(negedge Clk);
    endtask

    task automatic read_all();
        @(negedge Clk);
        Weight_Load_enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            rb[k] = New_weight_out;
            if (k == 39) Weight_Load_enable = 1'b0;
        end
        @(negedge Clk);
    endtask

    task automatic set_x(input longint a, input longint b, input longint c, input longint d);
        m_x[0] = a; m_x[1] = b; m_x[2] = c; m_x[3] = d;
        t0 = WB'(a); t1 = WB'(b); t2 = WB'(c); t3 = WB'(d);
    endtask

    task automatic run_inference(input bit hold, input bit train);
        @(negedge Clk);
        training_enable_h = train;
        tb_rev_ready_h = 1'b1;
        pulses = 0; ready_cyc = 0; got = '0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge Clk);
            if (!hold && cyc == 1) tb_rev_ready_h = 1'b0;
            if (Ready_Signal) begin
                pulses++;
                if (ready_cyc == 0) begin
                    ready_cyc = cyc;
                    got = Data_out;
                end
            end
        end
        tb_rev_ready_h = 1'b0;
        training_enable_h = 1'b0;
        @(negedge Clk);
    endtask

    task automatic load_scenario2();
        for (int k = 0; k < 32; k++) m_w[k] = 1000;
        for (int k = 32; k < 40; k++) m_w[k] = 125;
        write_all();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (Data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%0d want=0", Data_out); end
        checks++;
        if (New_weight_out !== '0) begin failures++; $display("FAIL reset_new_weight got=%0d want=0", New_weight_out); end
        checks++;
        if (Ready_Signal !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b want=0", Ready_Signal); end
    endtask

    task automatic test_zero_weights();
        set_x(5, 6, 7, 8);
        run_inference(1'b0, 1'b0);
        checks++;
        if (got !== '0) begin failures++; $display("FAIL zero_w_data got=%0d want=0", got); end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL zero_w_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_scenario2();
        load_scenario2();
        set_x(10, 20, 30, 40);
        run_inference(1'b0, 1'b0);
        exp_v = WB'(100000);
        checks++;
        if (got !== exp_v) begin failures++; $display("FAIL scen2_data got=%0d want=%0d", got, exp_v); end
        checks++;
        if (ready_cyc != 4) begin failures++; $display("FAIL scen2_latency got=%0d want=4", ready_cyc); end
        checks++;
        if (Data_out !== exp_v) begin failures++; $display("FAIL scen2_hold got=%0d want=%0d", Data_out, exp_v); end
    endtask

    task automatic test_relu();
        set_x(-1, -1, -1, -1);
        run_inference(1'b0, 1'b0);
        checks++;
        if (got !== '0) begin failures++; $display("FAIL relu_clamp got=%0d want=0", got); end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL relu_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_hold_high();
        set_x(10, 20, 30, 40);
        run_inference(1'b1, 1'b0);
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL hold_no_retrigger got=%0d want=1", pulses); end
    endtask

    task automatic test_readback();
        for (int k = 0; k < 40; k++) m_w[k] = k + 1;
        write_all();
        read_all();
        for (int k = 0; k < 40; k++) begin
            exp_v = WB'(k + 1);
            checks++;
            if (rb[k] !== exp_v) begin failures++; $display("FAIL readback_%0d got=%0d want=%0d", k, rb[k], exp_v); end
        end
    endtask

    task automatic test_ptr_restart();
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            Weight_Save_enable = 1'b1;
            Weight_in = WB'(501 + k);
            m_w[k] = 501 + k;
        end
        @(negedge Clk);
        Weight_Save_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            Weight_Save_enable = 1'b1;
            Weight_in = WB'(901 + k);
            m_w[k] = 901 + k;
        end
        @(negedge Clk);
        Weight_Save_enable = 1'b0;
        @(negedge Clk);
        read_all();
        for (int k = 0; k < 12; k++) begin
            exp_v = WB'(m_w[k]);
            checks++;
            if (rb[k] !== exp_v) begin failures++; $display("FAIL ptr_restart_%0d got=%0d want=%0d", k, rb[k], exp_v); end
        end
    endtask

    task automatic test_training();
        apply_reset();
        load_scenario2();
        set_x(10, 20, 30, 40);
        Target = WB'(120);
        run_inference(1'b0, 1'b1);
        exp_v = WB'(100000);
        checks++;
        if (got !== exp_v) begin failures++; $display("FAIL train_first got=%0d want=%0d", got, exp_v); end
        read_all();
        for (int k = 0; k < 40; k++) begin
            exp_v = (k < 32) ? WB'(1000) : WB'(126);
            checks++;
            if (rb[k] !== exp_v) begin failures++; $display("FAIL train_w_%0d got=%0d want=%0d", k, rb[k], exp_v); end
        end
        run_inference(1'b0, 1'b0);
        exp_v = WB'(100800);
        checks++;
        if (got !== exp_v) begin failures++; $display("FAIL train_after got=%0d want=%0d", got, exp_v); end
    endtask

    task automatic test_random();
        longint y, tgt;
        bit     tr;
        apply_reset();
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 40; k++) m_w[k] = longint'($urandom_range(0, 4000)) - 2000;
            write_all();
            set_x(longint'($urandom_range(0, 100)) - 50, longint'($urandom_range(0, 100)) - 50,
                  longint'($urandom_range(0, 100)) - 50, longint'($urandom_range(0, 100)) - 50);
            tgt = longint'($urandom_range(0, 60)) - 10;
            Target = WB'(tgt);
            tr = 1'($urandom_range(0, 1));
            y = model_forward();
            run_inference(1'b0, tr);
            exp_v = WB'(y);
            checks++;
            if (got !== exp_v) begin failures++; $display("FAIL rand_%0d_data got=%0d want=%0d", it, got, exp_v); end
            if (tr) model_train(tgt, y);
            read_all();
            for (int k = 32; k < 40; k++) begin
                exp_v = WB'(m_w[k]);
                checks++;
                if (rb[k] !== exp_v) begin failures++; $display("FAIL rand_%0d_w%0d got=%0d want=%0d", it, k, rb[k], exp_v); end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        load_scenario2();
        set_x(10, 20, 30, 40);
        @(negedge Clk);
        tb_rev_ready_h = 1'b1;
        @(negedge Clk);
        tb_rev_ready_h = 1'b0;
        @(negedge Clk);
        checks++;
        if (dut.state_q !== S_HIDDEN) begin failures++; $display("FAIL midrst_pre_state got=%0d want=%0d", dut.state_q, S_HIDDEN); end
        Reset_l = 1'b1;
        for (int k = 0; k < 40; k++) m_w[k] = 0;
        @(negedge Clk);
        checks++;
        if (dut.state_q !== S_IDLE) begin failures++; $display("FAIL midrst_state got=%0d want=%0d", dut.state_q, S_IDLE); end
        checks++;
        if (Data_out !== '0) begin failures++; $display("FAIL midrst_data got=%0d want=0", Data_out); end
        checks++;
        if (Ready_Signal !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%0b want=0", Ready_Signal); end
        Reset_l = 1'b0;
        @(negedge Clk);
        run_inference(1'b0, 1'b0);
        checks++;
        if (got !== '0) begin failures++; $display("FAIL midrst_next got=%0d want=0", got); end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL midrst_pulses got=%0d want=1", pulses); end
    endtask

    initial begin
        test_reset();
        test_zero_weights();
        test_scenario2();
        test_relu();
        test_hold_high();
        test_readback();
        test_ptr_restart();
        test_training();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ann.md
# ann

Fixed-size feed-forward neural network for daily minimum-temperature prediction: 4 inputs, 8 ReLU hidden neurons and 1 linear output, using 40 signed integer weights scaled by 1000. The host loads weights over a serial bus, presents four consecutive daily temperatures and handshakes a single inference. It can read the weights back. An optional training pass updates the output-layer weights by LMS. It sits between the host/data loader and the prediction writer.

## Interface
- INPUT_SIZE, 13, width factor; all data/weight buses are W = INPUT_SIZE*12 = 156 bits, two's complement signed
- INPUT_NUM, 4, inputs per sample
- NEURON_NUM, 8, hidden neurons; weight count NW = INPUT_NUM*NEURON_NUM + NEURON_NUM = 40
- Clk  in  1  sole clock, rising edge
- Reset_l  in  1  reset, asynchronous, active-high (asserted = 1)
- Temperature_in_0..Temperature_in_3  in  W each  inputs x0..x3 (oldest first)
- Weight_in  in  W  weight write data
- Target  in  W  training target, same units as inputs
- training_enable_h  in  1  1: perform output-layer update after inference
- tb_rev_ready_h  in  1  start request; inference launched on its rising edge
- Weight_Save_enable  in  1  serial weight write strobe, one weight per cycle
- Weight_Load_enable  in  1  serial weight read strobe, one weight per cycle
- Data_out  out  W  prediction ×1000 (host divides by 1000); reset 0
- New_weight_out  out  W  weight read data; reset 0
- Ready_Signal  out  1  one-cycle result-valid pulse; reset 0

## Operation
- Weight memory w[0..39]: w[4j+i] = hidden neuron j, input i; w[32+j] = output weight j. Reset clears all to 0.
- Save: in IDLE, each cycle with Weight_Save_enable=1 writes w[ptr] <= Weight_in and ptr++ (wraps 39→0). Any cycle with both strobes low sets ptr <= 0.
- Load: in IDLE with Weight_Save_enable=0, each cycle with Weight_Load_enable=1 sets New_weight_out <= w[ptr] and ptr++. Save has priority when both strobes are high.
- Strobes are ignored outside IDLE.
- Hidden layer: s_j = Σ_i w[4j+i]·x_i. h_j = (s_j > 0) ? s_j/1000 : 0, with truncating division.
- Output layer: y = Σ_j w[32+j]·h_j. Data_out <= y.
- All arithmetic is signed and truncated to W bits.
- Training: err = Target·1000 − y. Each output weight is updated as w[32+j] += (err·h_j) >>> 20, an arithmetic shift. Hidden weights are never trained.
- FSM states and transitions:
  - IDLE → LATCH on a tb_rev_ready_h rising edge.
  - LATCH: x_i registered → HIDDEN.
  - HIDDEN: h_j registered → OUTPUT.
  - OUTPUT: Data_out registered, Ready_Signal=1 → UPDATE if training_enable_h else IDLE.
  - UPDATE: weights written → IDLE.
- tb_rev_ready_h held high does not retrigger; it must return low first. Requests while busy are ignored.
- Data_out holds its value until the next OUTPUT state.

## Timing
- Rising-edge detect of tb_rev_ready_h uses its registered previous value. From the first edge sampling 1, Data_out and Ready_Signal update on the 3rd edge after it (latency ≤ 4 cycles). The host samples Data_out 5 cycles after asserting tb_rev_ready_h.
- Ready_Signal is high for exactly one cycle.
- With training, the weight update completes 1 cycle after Ready_Signal.
- New_weight_out has 1-cycle latency after the strobed edge.
- Reset mid-operation: immediate return to IDLE; all outputs, weights and ptr go to 0.

## Structure
- Shared package: W, NW, scale constant 1000, LMS shift 20, FSM state enum.
- One natural sub-module, ann_neuron: a 4-input MAC with ReLU and /1000, instantiated 8×.
- The output MAC and LMS logic stay in the top level.

## Test plan
- Reset: all outputs 0. Inference with untouched weights → Data_out=0, Ready_Signal pulses once.
- Hidden weights all 1000, output weights all 125, x = 10,20,30,40 → h_j=100, Data_out=100000 (host value 100) by the 3rd edge.
- Same weights, all x = −1 → ReLU clamps → Data_out=0.
- Write w[k]=k+1 for 40 cycles, then Load for 40 cycles → New_weight_out = 1..40 in order, 1-cycle latency. Write 10 weights, drop the strobe, write again → the second write starts at w[0].
- Training with the scenario-2 setup and Target=120 → err=20000, delta=1, all w[32..39]=126. A readback confirms this and the next inference gives 100800.
- Reset_l asserted during HIDDEN → state IDLE, Data_out=0, and the next inference returns 0.
